// File: rtl/mdu_iter_if.sv
// Pipeline-to-MDU bundle: request (start/op/operands/flush) toward the unit, HI/LO and status back.
interface mdu_iter_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   modport master (output start, op, a, b, flush, input hi, lo, busy, done);
   modport slave  (input start, op, a, b, flush, output hi, lo, busy, done);
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO; mul/div take WIDTH+1 busy cycles.
// Requests are dropped (not queued) while busy; flush aborts without touching HI/LO.
module mdu_iter #(
   parameter int  WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input logic       clk,
   input logic       rst_n,
   mdu_iter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               a_neg_q, a_neg_d;
   logic               done_q, done_d;

   logic               sgn;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     add_x, add_y;
   logic [WIDTH+1:0]   sum;
   logic [WIDTH-1:0]   quo, rem;

   // One shared adder: multiply adds the multiplicand to the upper half,
   // divide subtracts the divisor from the shifted partial remainder.
   always_comb begin
      add_x = '0;
      add_y = '0;
      if (is_div_q) begin
         add_x = acc_q[2*WIDTH-1:WIDTH-1];
         add_y = ~{1'b0, opb_q};
      end else begin
         add_x = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
         add_y = {1'b0, acc_q[0] ? opb_q : {WIDTH{1'b0}}};
      end
      sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, is_div_q};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      a_neg_d  = a_neg_q;
      done_d   = 1'b0;
      sgn      = ~bus.op[0];
      a_mag    = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_mag    = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      quo      = neg_q   ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
      rem      = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

      case (state_q)
         IDLE: begin
            if (bus.start && !bus.flush) begin
               if (!bus.op[2]) begin
                  acc_d    = {{WIDTH{1'b0}}, a_mag};
                  opb_d    = b_mag;
                  is_div_d = bus.op[1];
                  neg_d    = sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  a_neg_d  = sgn & bus.a[WIDTH-1];
                  cnt_d    = '0;
                  state_d  = CALC;
               end else if (bus.op == 3'b100) begin
                  hi_d = bus.a;
               end else if (bus.op == 3'b101) begin
                  lo_d = bus.a;
               end
            end
         end
         CALC: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else begin
               if (is_div_q) begin
                  acc_d = sum[WIDTH+1] ? {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                       : {acc_q[2*WIDTH-2:0], 1'b0};
               end else begin
                  acc_d = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!bus.flush) begin
               done_d = 1'b1;
               if (is_div_q) begin
                  // A zero divisor leaves |a| as remainder, so the dividend-sign
                  // fix already restores a in HI; only LO needs forcing.
                  lo_d = (opb_q == '0) ? {WIDTH{1'b1}} : quo;
                  hi_d = rem;
               end else begin
                  {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         a_neg_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         a_neg_q  <= a_neg_d;
         done_q   <= done_d;
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
endmodule
